// File: rtl/channel_acq_sequencer_if.sv
// Trigger, channel and event-FIFO signal bundle between the acquisition sequencer
// and its neighbours (TTC receiver, Channel FPGAs, event FIFO).
interface channel_acq_sequencer_if #(
    parameter int N_CHAN = 5,
    parameter int TYPE_W = 3,
    parameter int NUM_W  = 24
);
    localparam int FIFO_W = 1 + N_CHAN + TYPE_W + NUM_W;

    logic                trigger;
    logic [TYPE_W-1:0]   trig_type;
    logic [NUM_W-1:0]    trig_num;
    logic                acq_ready;
    logic [N_CHAN-1:0]   acq_dones;
    logic [2*N_CHAN-1:0] acq_enable;
    logic [N_CHAN-1:0]   acq_trig;
    logic                fifo_ready;
    logic                fifo_valid;
    logic [FIFO_W-1:0]   fifo_data;

    modport master (
        input  trigger, trig_type, trig_num, acq_dones, fifo_ready,
        output acq_ready, acq_enable, acq_trig, fifo_valid, fifo_data
    );

    modport slave (
        output trigger, trig_type, trig_num, acq_dones, fifo_ready,
        input  acq_ready, acq_enable, acq_trig, fifo_valid, fifo_data
    );
endinterface

// File: rtl/channel_acq_sequencer.sv
// Trigger sequencer: queues TTC triggers and walks each one through
// DELAY -> FILL -> STORE towards the Channel FPGAs and the event FIFO.
module channel_acq_sequencer #(
    parameter int N_CHAN  = 5,
    parameter int TYPE_W  = 3,
    parameter int NUM_W   = 24,
    parameter int DELAY_W = 32,
    parameter int TMO_W   = 24,
    parameter int QDEPTH  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CHAN-1:0]        chan_en,
    input  logic [DELAY_W-1:0]       trig_delay,
    input  logic [TMO_W-1:0]         fill_timeout,
    input  logic                     async_mode,
    channel_acq_sequencer_if.master  bus,
    output logic [CNT_W-1:0]         overflow_cnt,
    output logic [CNT_W-1:0]         timeout_cnt,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [3:0]               state
);
    localparam int QA_W   = $clog2(QDEPTH);
    localparam int FIFO_W = 1 + N_CHAN + TYPE_W + NUM_W;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_DELAY = 4'b0010;
    localparam logic [3:0] ST_FILL  = 4'b0100;
    localparam logic [3:0] ST_STORE = 4'b1000;

    localparam logic [QA_W:0]    QCNT_FULL = (QA_W+1)'(QDEPTH);
    localparam logic [QA_W:0]    QCNT_ZERO = {(QA_W+1){1'b0}};
    localparam logic [QA_W:0]    QCNT_ONE  = {{QA_W{1'b0}}, 1'b1};
    localparam logic [QA_W-1:0]  QA_ONE    = {{(QA_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] DLY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [TYPE_W-1:0]   q_type_r [QDEPTH];
    logic [NUM_W-1:0]    q_num_r  [QDEPTH];
    logic [QA_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [QA_W:0]       count_r, count_nx_s;
    logic                trig_s, full_s, push_s, drop_s, pop_s;

    logic [3:0]          state_r, state_nx_s;
    logic [TYPE_W-1:0]   type_r, type_src_s;
    logic [NUM_W-1:0]    num_r;
    logic [N_CHAN-1:0]   mask_r, mask_src_s;
    logic [DELAY_W-1:0]  delay_r, dly_cnt_r;
    logic [TMO_W-1:0]    tmo_r, fill_cnt_r;
    logic                delay_done_s, done_s, tmo_exit_s;

    logic                acq_ready_r, acq_ready_nx_s;
    logic [2*N_CHAN-1:0] acq_enable_r, acq_enable_nx_s;
    logic [N_CHAN-1:0]   acq_trig_r, acq_trig_nx_s;
    logic                fifo_valid_r, fifo_valid_nx_s;
    logic [FIFO_W-1:0]   fifo_data_r, fifo_data_nx_s;
    logic [CNT_W-1:0]    overflow_cnt_r, overflow_cnt_nx_s;
    logic [CNT_W-1:0]    timeout_cnt_r, timeout_cnt_nx_s;

    // Queue push/pop/drop decisions and next occupancy.
    always_comb begin
        trig_s = bus.trigger & ~async_mode;
        full_s = (count_r == QCNT_FULL);
        push_s = trig_s & ~full_s;
        drop_s = trig_s & full_s;
        pop_s  = (state_r == ST_IDLE) && (count_r != QCNT_ZERO);
        if (push_s && !pop_s) begin
            count_nx_s = count_r + QCNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nx_s = count_r - QCNT_ONE;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Pending-trigger queue storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_type_r[i] <= {TYPE_W{1'b0}};
                q_num_r[i]  <= {NUM_W{1'b0}};
            end
            wr_ptr_r <= {QA_W{1'b0}};
            rd_ptr_r <= {QA_W{1'b0}};
            count_r  <= QCNT_ZERO;
        end else begin
            if (push_s) begin
                q_type_r[wr_ptr_r] <= bus.trig_type;
                q_num_r[wr_ptr_r]  <= bus.trig_num;
                wr_ptr_r           <= wr_ptr_r + QA_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + QA_ONE;
            end
            count_r <= count_nx_s;
        end
    end

    // Per-trigger context latched at dequeue, plus DELAY/FILL cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_r     <= {TYPE_W{1'b0}};
            num_r      <= {NUM_W{1'b0}};
            mask_r     <= {N_CHAN{1'b0}};
            delay_r    <= {DELAY_W{1'b0}};
            tmo_r      <= TMO_ZERO;
            dly_cnt_r  <= {DELAY_W{1'b0}};
            fill_cnt_r <= TMO_ZERO;
        end else begin
            if (pop_s) begin
                type_r  <= q_type_r[rd_ptr_r];
                num_r   <= q_num_r[rd_ptr_r];
                mask_r  <= chan_en;
                delay_r <= trig_delay;
                tmo_r   <= fill_timeout;
            end
            if (state_r == ST_DELAY) begin
                dly_cnt_r <= dly_cnt_r + DLY_ONE;
            end else begin
                dly_cnt_r <= {DELAY_W{1'b0}};
            end
            // With the timeout disabled the FILL counter idles so it can never wrap.
            if ((state_r == ST_FILL) && (tmo_r != TMO_ZERO)) begin
                fill_cnt_r <= fill_cnt_r + TMO_ONE;
            end else begin
                fill_cnt_r <= TMO_ZERO;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a done in the timeout cycle takes precedence.
    always_comb begin
        delay_done_s = (dly_cnt_r == (delay_r - DLY_ONE));
        done_s       = ((bus.acq_dones & mask_r) == mask_r);
        tmo_exit_s   = (tmo_r != TMO_ZERO) && (fill_cnt_r == (tmo_r - TMO_ONE)) && !done_s;
        state_nx_s   = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nx_s = (trig_delay != {DELAY_W{1'b0}}) ? ST_DELAY : ST_FILL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                state_nx_s = delay_done_s ? ST_FILL : ST_DELAY;
            end
            ST_FILL: begin
                state_nx_s = (done_s || tmo_exit_s) ? ST_STORE : ST_FILL;
            end
            ST_STORE: begin
                state_nx_s = bus.fifo_ready ? ST_IDLE : ST_STORE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        mask_src_s = (state_r == ST_IDLE) ? chan_en : mask_r;
        type_src_s = (state_r == ST_IDLE) ? q_type_r[rd_ptr_r] : type_r;
        if (state_nx_s == ST_FILL) begin
            acq_trig_nx_s   = mask_src_s;
            acq_enable_nx_s = {N_CHAN{type_src_s[1:0]}};
        end else begin
            acq_trig_nx_s   = {N_CHAN{1'b0}};
            acq_enable_nx_s = {(2*N_CHAN){1'b0}};
        end
        if ((state_r == ST_FILL) && (state_nx_s == ST_STORE)) begin
            fifo_valid_nx_s = 1'b1;
            fifo_data_nx_s  = {tmo_exit_s, bus.acq_dones & mask_r, type_r, num_r};
        end else if ((state_r == ST_STORE) && bus.fifo_ready) begin
            fifo_valid_nx_s = 1'b0;
            fifo_data_nx_s  = {FIFO_W{1'b0}};
        end else begin
            fifo_valid_nx_s = fifo_valid_r;
            fifo_data_nx_s  = fifo_data_r;
        end
        acq_ready_nx_s = (count_nx_s != QCNT_FULL);
        if (drop_s && (overflow_cnt_r != CNT_MAX)) begin
            overflow_cnt_nx_s = overflow_cnt_r + CNT_ONE;
        end else begin
            overflow_cnt_nx_s = overflow_cnt_r;
        end
        if ((state_r == ST_FILL) && tmo_exit_s && (timeout_cnt_r != CNT_MAX)) begin
            timeout_cnt_nx_s = timeout_cnt_r + CNT_ONE;
        end else begin
            timeout_cnt_nx_s = timeout_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acq_ready_r    <= 1'b1;
            acq_enable_r   <= {(2*N_CHAN){1'b0}};
            acq_trig_r     <= {N_CHAN{1'b0}};
            fifo_valid_r   <= 1'b0;
            fifo_data_r    <= {FIFO_W{1'b0}};
            overflow_cnt_r <= {CNT_W{1'b0}};
            timeout_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            acq_ready_r    <= acq_ready_nx_s;
            acq_enable_r   <= acq_enable_nx_s;
            acq_trig_r     <= acq_trig_nx_s;
            fifo_valid_r   <= fifo_valid_nx_s;
            fifo_data_r    <= fifo_data_nx_s;
            overflow_cnt_r <= overflow_cnt_nx_s;
            timeout_cnt_r  <= timeout_cnt_nx_s;
        end
    end

    assign bus.acq_ready  = acq_ready_r;
    assign bus.acq_enable = acq_enable_r;
    assign bus.acq_trig   = acq_trig_r;
    assign bus.fifo_valid = fifo_valid_r;
    assign bus.fifo_data  = fifo_data_r;
    assign overflow_cnt   = overflow_cnt_r;
    assign timeout_cnt    = timeout_cnt_r;
    assign q_count        = count_r;
    assign state          = state_r;
endmodule
